// File: rtl/cdb_grant_controller.sv
// Grant controller for the two common data buses: per-bus offer/own/release FSMs
// sharing one round-robin pointer, with ack timeout and revocation.
module cdb_grant_controller #(
  parameter int         NUM_UNITS    = 8,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter logic [7:0] IDLE_ADDRESS = 8'hFF,
  parameter int         TIMEOUT      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] request,
  input  logic [1:0]           ack,
  input  logic [1:0]           bus_release,
  output logic [7:0]           select_0,
  output logic [7:0]           select_1,
  output logic [1:0]           busy,
  output logic [1:0]           timeout_err
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  if (int'(BASE_ADDRESS) + NUM_UNITS - 1 >= int'(IDLE_ADDRESS)) begin : g_addr_check
    $error("cdb_grant_controller: unit address range overlaps IDLE_ADDRESS");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("cdb_grant_controller: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, OFFER, OWNED} state_t;

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [IDX_W-1:0] owner_q [2];
  logic [IDX_W-1:0] owner_d [2];
  logic [7:0]       sel_q   [2];
  logic [7:0]       sel_d   [2];
  logic [1:0]       to_q, to_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [NUM_UNITS-1:0] eligible;
  logic                 found_a, found_b;
  logic [IDX_W-1:0]     pick_a, pick_b;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_UNITS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // A unit already offered or owning one bus may not be offered the other.
  always_comb begin
    eligible = request;
    for (int k = 0; k < 2; k++) begin
      if (state_q[k] != IDLE) eligible[owner_q[k]] = 1'b0;
    end
  end

  // First and second eligible units in round-robin order starting at rr_q.
  always_comb begin
    int idx;
    idx     = 0;
    found_a = 1'b0;
    found_b = 1'b0;
    pick_a  = '0;
    pick_b  = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      idx = (int'(rr_q) + off) % NUM_UNITS;
      if (eligible[idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          pick_a  = IDX_W'(idx);
        end else if (!found_b) begin
          found_b = 1'b1;
          pick_b  = IDX_W'(idx);
        end
      end
    end
  end

  // A grant in the same cycle as a revocation decides the new rr pointer.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      owner_d[k] = owner_q[k];
      sel_d[k]   = sel_q[k];
    end
    to_d = '0;
    rr_d = rr_q;

    for (int k = 0; k < 2; k++) begin
      case (state_q[k])
        OFFER: begin
          if (ack[k]) begin
            state_d[k] = bus_release[k] ? IDLE : OWNED;
            cnt_d[k]   = '0;
            if (bus_release[k]) sel_d[k] = IDLE_ADDRESS;
          end else if (cnt_q[k] == CNT_W'(TIMEOUT - 1)) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
            sel_d[k]   = IDLE_ADDRESS;
            to_d[k]    = 1'b1;
            rr_d       = wrap_inc(owner_q[k]);
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        OWNED: begin
          if (bus_release[k]) begin
            state_d[k] = IDLE;
            sel_d[k]   = IDLE_ADDRESS;
          end
        end
        default: ;
      endcase
    end

    if (state_q[0] == IDLE && found_a) begin
      state_d[0] = OFFER;
      cnt_d[0]   = '0;
      owner_d[0] = pick_a;
      sel_d[0]   = BASE_ADDRESS + 8'(pick_a);
      rr_d       = wrap_inc(pick_a);
    end
    if (state_q[1] == IDLE) begin
      if (state_q[0] == IDLE) begin
        if (found_b) begin
          state_d[1] = OFFER;
          cnt_d[1]   = '0;
          owner_d[1] = pick_b;
          sel_d[1]   = BASE_ADDRESS + 8'(pick_b);
          rr_d       = wrap_inc(pick_b);
        end
      end else if (found_a) begin
        state_d[1] = OFFER;
        cnt_d[1]   = '0;
        owner_d[1] = pick_a;
        sel_d[1]   = BASE_ADDRESS + 8'(pick_a);
        rr_d       = wrap_inc(pick_a);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
        owner_q[k] <= '0;
        sel_q[k]   <= IDLE_ADDRESS;
      end
      to_q <= '0;
      rr_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        owner_q[k] <= owner_d[k];
        sel_q[k]   <= sel_d[k];
      end
      to_q <= to_d;
      rr_q <= rr_d;
    end
  end

  assign select_0    = sel_q[0];
  assign select_1    = sel_q[1];
  assign busy        = {state_q[1] != IDLE, state_q[0] != IDLE};
  assign timeout_err = to_q;

endmodule
